// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache for the fetch stage.
// Lookups are combinational in IDLE; a miss refills one whole line word-by-word from backing memory.
module instr_cache #(
    parameter int                         ADDRESS_WIDTH  = 32,
    parameter int                         DATA_WIDTH     = 32,
    parameter int                         SETS           = 16,
    parameter int                         WORDS_PER_LINE = 4,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR      = 32'hBFC00000,
    parameter int                         REGION_BYTES   = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ADDRESS_WIDTH-1:0] A,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    RD,
    output logic                     hit,
    output logic                     stall,
    output logic                     fault,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_valid
);

    localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
    localparam int OFF       = 2 + WORD_BITS;
    localparam int IDX       = $clog2(SETS);
    localparam int TAG_W     = ADDRESS_WIDTH - OFF - IDX;
    localparam int CNT_W     = (WORD_BITS > 0) ? WORD_BITS : 1;

    localparam logic [CNT_W-1:0]       LAST_WORD   = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDRESS_WIDTH:0] REGION_SIZE = (ADDRESS_WIDTH + 1)'(REGION_BYTES);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_REFILL = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [TAG_W-1:0] line_tag;
    logic [IDX-1:0]   line_idx;
    logic             flush_pending;
    logic [SETS-1:0]  valid;

    logic [DATA_WIDTH-1:0] data_mem [SETS][WORDS_PER_LINE];
    logic [TAG_W-1:0]      tag_mem  [SETS];

    logic [TAG_W-1:0]       a_tag;
    logic [IDX-1:0]         a_idx;
    logic [CNT_W-1:0]       a_word;
    logic [ADDRESS_WIDTH:0] a_offset;
    logic                   in_range;
    logic                   idle_lookup;
    logic                   tag_match;
    logic                   miss;
    logic                   refill_beat;
    logic                   last_beat;

    assign a_tag  = A[ADDRESS_WIDTH-1:OFF+IDX];
    assign a_idx  = A[OFF+IDX-1:OFF];
    // Masking keeps the word select at zero when a line holds a single word.
    assign a_word = A[CNT_W+1:2] & LAST_WORD;

    // A borrow out of the subtraction means A lies below the region base.
    assign a_offset = {1'b0, A} - {1'b0, BASE_ADDR};
    assign in_range = ~a_offset[ADDRESS_WIDTH] && (a_offset < REGION_SIZE);

    assign idle_lookup = ~rst && (state == S_IDLE) && en;
    assign fault       = idle_lookup && ((A[1:0] != 2'b00) || ~in_range);
    assign tag_match   = valid[a_idx] && (tag_mem[a_idx] == a_tag);
    assign hit         = idle_lookup && ~fault && ~flush && tag_match;
    assign miss        = idle_lookup && ~fault && ~hit;
    assign stall       = miss || (~rst && (state == S_REFILL));
    assign RD          = hit ? data_mem[a_idx][a_word] : '0;

    assign mem_req     = (state == S_REFILL);
    assign mem_addr    = {line_tag, line_idx, {OFF{1'b0}}} | (ADDRESS_WIDTH'(cnt) << 2);
    assign refill_beat = (state == S_REFILL) && mem_valid;
    assign last_beat   = refill_beat && (cnt == LAST_WORD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            flush_pending <= 1'b0;
            valid         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end
                    if (miss) begin
                        state    <= S_REFILL;
                        line_tag <= a_tag;
                        line_idx <= a_idx;
                        cnt      <= '0;
                    end
                end
                S_REFILL: begin
                    if (flush) begin
                        flush_pending <= 1'b1;
                    end
                    if (last_beat) begin
                        // A flush seen during the refill also drops the line just filled.
                        state         <= S_IDLE;
                        cnt           <= '0;
                        flush_pending <= 1'b0;
                        if (flush_pending || flush) begin
                            valid <= '0;
                        end else begin
                            valid[line_idx] <= 1'b1;
                        end
                    end else if (refill_beat) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Data and tag arrays carry no reset; the valid vector alone qualifies them.
    always_ff @(posedge clk) begin
        if (!rst && refill_beat) begin
            data_mem[line_idx][cnt] <= mem_rdata;
            if (cnt == LAST_WORD) begin
                tag_mem[line_idx] <= line_tag;
            end
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: stimulus queues expected fetch words and backing addresses,
// a monitor pops them whenever the cache hits or accepts a refill beat.
module tb_instr_cache;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] A;
    logic        flush;
    logic [31:0] RD;
    logic        hit;
    logic        stall;
    logic        fault;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    int errors = 0;
    int checks = 0;
    int wait_states = 0;
    int wait_ctr = 0;

    logic [31:0] exp_rd[$];
    logic [31:0] exp_addr[$];

    instr_cache dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .A         (A),
        .flush     (flush),
        .RD        (RD),
        .hit       (hit),
        .stall     (stall),
        .fault     (fault),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid)
    );

    function automatic logic [31:0] memModel(input logic [31:0] addr);
        return addr ^ 32'hA5A5A5A5;
    endfunction

    assign mem_rdata = memModel(mem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Backing memory: answers each requested word after wait_states idle cycles.
    initial begin
        mem_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (wait_ctr < wait_states) begin
                    mem_valid = 1'b0;
                    wait_ctr++;
                end else begin
                    mem_valid = 1'b1;
                    wait_ctr = 0;
                end
            end else begin
                mem_valid = 1'b0;
                wait_ctr = 0;
            end
        end
    end

    // Monitor compares every hit word and every accepted refill address against the queues.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (hit) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected hit: A=%h RD=%h, expected no hit", A, RD);
                end else begin
                    e = exp_rd.pop_front();
                    if (RD !== e) begin
                        errors++;
                        $display("[TB] FAIL hit data A=%h: got %h, expected %h", A, RD, e);
                    end
                end
            end
            if (mem_req && mem_valid) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected refill beat: mem_addr=%h, expected none", mem_addr);
                end else begin
                    e = exp_addr.pop_front();
                    if (mem_addr !== e) begin
                        errors++;
                        $display("[TB] FAIL refill addr: got %h, expected %h", mem_addr, e);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Fetch addr until it hits; flush is pulsed in stall cycle flush_at (negative = never).
    task automatic applyStimulus(input string name, input logic [31:0] addr, input int exp_stall,
                                 input int exp_refills, input int flush_at);
        int n;
        for (int r = 0; r < exp_refills; r++) begin
            for (int w = 0; w < 4; w++) begin
                exp_addr.push_back({addr[31:4], 4'h0} + 32'(4 * w));
            end
        end
        exp_rd.push_back(memModel(addr));
        en    = 1'b1;
        A     = addr;
        flush = (flush_at == 0);
        n     = 0;
        #1;
        while (!hit && n < 100) begin
            checkOutput({name, " stall during miss"}, {31'b0, stall}, 32'd1);
            n++;
            nextCycle();
            flush = (n == flush_at);
            #1;
        end
        flush = 1'b0;
        if (!hit) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: hit=0 after %0d cycles, expected hit", name, n);
        end
        checkOutput({name, " stall cycles"}, 32'(n), 32'(exp_stall));
        checkOutput({name, " stall on hit"}, {31'b0, stall}, 32'd0);
        checkOutput({name, " mem_req on hit"}, {31'b0, mem_req}, 32'd0);
        nextCycle();
        en = 1'b0;
    endtask

    task automatic checkFault(input string name, input logic [31:0] addr);
        en = 1'b1;
        A  = addr;
        #1;
        checkOutput({name, " fault"}, {31'b0, fault}, 32'd1);
        checkOutput({name, " stall"}, {31'b0, stall}, 32'd0);
        checkOutput({name, " hit"}, {31'b0, hit}, 32'd0);
        checkOutput({name, " RD"}, RD, 32'd0);
        nextCycle();
        checkOutput({name, " mem_req next"}, {31'b0, mem_req}, 32'd0);
        en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        A     = 32'hBFC00000;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset hit", {31'b0, hit}, 32'd0);
        checkOutput("reset stall", {31'b0, stall}, 32'd0);
        checkOutput("reset fault", {31'b0, fault}, 32'd0);
        checkOutput("reset RD", RD, 32'd0);
        checkOutput("reset mem_req", {31'b0, mem_req}, 32'd0);
        rst = 1'b0;
        en  = 1'b0;
        #1;
        checkOutput("idle en=0 stall", {31'b0, stall}, 32'd0);
        checkOutput("idle en=0 hit", {31'b0, hit}, 32'd0);
        nextCycle();

        applyStimulus("cold fetch", 32'hBFC00000, 5, 1, -1);
        applyStimulus("spatial hit", 32'hBFC00008, 0, 0, -1);
        applyStimulus("last word hit", 32'hBFC0000C, 0, 0, -1);
        applyStimulus("conflict new tag", 32'hBFC00100, 5, 1, -1);
        applyStimulus("conflict refetch", 32'hBFC00000, 5, 1, -1);

        wait_states = 3;
        applyStimulus("wait states", 32'hBFC00040, 17, 1, -1);
        wait_states = 0;
        applyStimulus("wait states data", 32'hBFC00044, 0, 0, -1);

        applyStimulus("flush idle", 32'hBFC00040, 5, 1, 0);
        applyStimulus("flush mid refill", 32'hBFC00080, 10, 2, 3);

        // Reset lands while the refill of BFC00020 sits at cnt=1.
        exp_addr.push_back(32'hBFC00020);
        exp_addr.push_back(32'hBFC00024);
        en = 1'b1;
        A  = 32'hBFC00020;
        #1;
        checkOutput("rst-refill miss stall", {31'b0, stall}, 32'd1);
        nextCycle();
        nextCycle();
        rst = 1'b1;
        #1;
        checkOutput("rst-refill hit", {31'b0, hit}, 32'd0);
        checkOutput("rst-refill stall", {31'b0, stall}, 32'd0);
        checkOutput("rst-refill fault", {31'b0, fault}, 32'd0);
        checkOutput("rst-refill RD", RD, 32'd0);
        nextCycle();
        rst = 1'b0;
        en  = 1'b0;
        #1;
        checkOutput("rst-refill mem_req after", {31'b0, mem_req}, 32'd0);
        nextCycle();
        applyStimulus("after reset old line", 32'hBFC00080, 5, 1, -1);
        applyStimulus("after reset first fetch", 32'hBFC00020, 5, 1, -1);

        checkFault("misaligned", 32'hBFC00002);
        checkFault("above region", 32'hBFC01000);
        checkFault("below region", 32'hBFBFFFFC);
        applyStimulus("region top word", 32'hBFC00FFC, 5, 1, -1);

        repeat (3) nextCycle();
        checkOutput("rd queue drained", 32'(exp_rd.size()), 32'd0);
        checkOutput("addr queue drained", 32'(exp_addr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
